mpc_cycle_responder: RTL
========================

// Module: mpc_cycle_responder
// PURPOSE
//  Responder end of the start/done control-period handshake. Each start pulse from the
//  period generator launches one controller job. The block latches the measured state and
//  drives an iterative kernel for a bounded number of req/ack iterations. It then publishes
//  the actuation value and pulses done, which the period generator uses to measure job time.
// PARAMETERS
//  DATA_W    32    width of state, kernel and actuation words
//  ITER_W    8     width of iteration limit/counter
//  MAX_ITER  16    iteration cap; also used when iter_limit==0 (MAX_ITER < 2**ITER_W)
//  TIMEOUT   1024  max cycles waiting for k_ack in one iteration before abort
// PORTS
//  clk         in   1       clock, rising edge
//  reset       in   1       asynchronous, active-high reset
//  ce          in   1       clock enable; low freezes all state
//  start       in   1       job launch pulse
//  x_meas      in   DATA_W  measured state, sampled on accepted start
//  iter_limit  in   ITER_W  iterations per job, sampled on accepted start
//  clear_flags in   1       clears overrun/timeout_flag
//  k_req       out  1       kernel request (valid)
//  k_x         out  DATA_W  kernel operand
//  k_ack       in   1       kernel completion for current request
//  k_y         in   DATA_W  kernel result, valid with k_ack
//  done        out  1       job-complete pulse
//  u_out       out  DATA_W  actuation output, updated only on successful job
//  busy        out  1       high whenever FSM is not IDLE
//  iter_count  out  ITER_W  iterations completed in current/last job
//  overrun     out  1       sticky: start arrived while not IDLE
//  timeout_flag out 1       sticky: kernel failed to ack within TIMEOUT
// BEHAVIOUR
//  Reset (async): state=IDLE; k_req, k_x, done, u_out, busy, iter_count, flags all 0.
//   Reset mid-job aborts immediately; k_req drops asynchronously; no done is issued.
//  All sequential updates are qualified by ce. With ce=0, registers and outputs hold.
//   k_req = (state==REQ) & ce, so no handshake completes while ce=0.
//  FSM states: IDLE, REQ, FINISH.
//   IDLE: on start&ce, latch k_x<=x_meas, eff_limit, iter_count<=0, wd<=0; go to REQ.
//    eff_limit = (iter_limit==0 || iter_limit>MAX_ITER) ? MAX_ITER : iter_limit.
//   REQ: k_req high. Each ce cycle with k_ack=1 is one completed iteration:
//    k_x<=k_y, iter_count++, wd<=0. If the new iter_count==eff_limit, go to FINISH and
//    set ok=1. Back-to-back acks are allowed; k_req stays high between iterations.
//    Each ce cycle without k_ack increments wd. If wd reaches TIMEOUT-1 with no ack,
//    set timeout_flag, set ok=0 and go to FINISH.
//   FINISH: done=1 for this state only (exactly one ce-qualified cycle, registered).
//    If ok, u_out<=k_x (last kernel result); otherwise u_out holds its previous value.
//    Next state is IDLE.
//  busy is registered and equals (state!=IDLE).
//  Latency: start accepted at cycle t with zero-wait kernel (k_ack tied 1) and N iterations.
//   k_req is high at t+1..t+N, and done plus the new u_out are visible at t+N+1.
//   The next start is accepted from t+N+2 onward.
//  start while state!=IDLE (including during FINISH): ignored, overrun<=1.
//  clear_flags clears both flags. If a set event and clear_flags occur together, set wins.
//  k_ack while not in REQ is ignored. iter_count never wraps; it is bounded by eff_limit.
// TESTING
//  1 k_ack tied 1, iter_limit=4, start at t, x_meas=5 -> k_req high t+1..t+4; done at
//    t+5 only; iter_count=4; u_out equals the 4th k_y.
//  2 iter_limit=0, then 200 -> both jobs run exactly MAX_ITER=16 iterations.
//  3 Kernel acks after 3 wait cycles each, 2 iterations -> done at t+9; k_x is
//    chained k_y->k_x on each ack.
//  4 k_ack never asserted, TIMEOUT=1024 -> timeout_flag=1 and done pulse 1024 cycles
//    after k_req rises; u_out unchanged from the prior job.
//  5 Second start mid-job and during FINISH -> overrun=1, job continues, a single done is
//    issued; clear_flags coincident with a new overrun leaves overrun=1.
//  6 ce toggling 1/0 during a job -> same results as test 1 with stretched timing;
//    reset mid-REQ -> all outputs 0 at once and no done follows.

Source files
------------

// File: rtl/mpc_cycle_responder_if.sv
// Signal bundle between the period generator / kernel side and the cycle responder.
// The responder uses the slave view; the generator/kernel side uses the master view.
interface mpc_cycle_responder_if #(
  parameter int DATA_W = 32,
  parameter int ITER_W = 8
);
  logic                     ce;
  logic                     start;
  logic                     clear_flags;
  logic                     k_req;
  logic                     k_ack;
  logic                     done;
  logic                     busy;
  logic                     overrun;
  logic                     timeout_flag;
  logic signed [DATA_W-1:0] x_meas;
  logic signed [DATA_W-1:0] k_x;
  logic signed [DATA_W-1:0] k_y;
  logic signed [DATA_W-1:0] u_out;
  logic [ITER_W-1:0]        iter_limit;
  logic [ITER_W-1:0]        iter_count;

  modport slave (
    input  ce, start, x_meas, iter_limit, clear_flags, k_ack, k_y,
    output k_req, k_x, done, u_out, busy, iter_count, overrun, timeout_flag
  );

  modport master (
    output ce, start, x_meas, iter_limit, clear_flags, k_ack, k_y,
    input  k_req, k_x, done, u_out, busy, iter_count, overrun, timeout_flag
  );
endinterface

// File: rtl/mpc_cycle_responder.sv
// Responder for the start/done control-period handshake: runs one bounded iterative
// kernel job per accepted start and publishes the final kernel result as the actuation.
module mpc_cycle_responder #(
  parameter int DATA_W   = 32,
  parameter int ITER_W   = 8,
  parameter int MAX_ITER = 16,
  parameter int TIMEOUT  = 1024
) (
  input logic                  clk,
  input logic                  reset,
  mpc_cycle_responder_if.slave bus
);
  localparam int              WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [ITER_W-1:0] MAX_L   = ITER_W'(MAX_ITER);
  localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_FINISH} state_t;

  state_t                   state_q, state_d;
  logic signed [DATA_W-1:0] k_x_q, k_x_d;
  logic signed [DATA_W-1:0] u_out_q, u_out_d;
  logic [ITER_W-1:0]        iter_q, iter_d, eff_q, eff_d, iter_inc;
  logic [WD_W-1:0]          wd_q, wd_d;
  logic                     done_q, done_d, busy_q, busy_d;
  logic                     ovr_q, ovr_d, to_q, to_d;
  logic                     ovr_set, to_set;

  assign iter_inc = iter_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_x_q   <= '0;
      u_out_q <= '0;
      iter_q  <= '0;
      eff_q   <= '0;
      wd_q    <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      k_x_q   <= k_x_d;
      u_out_q <= u_out_d;
      iter_q  <= iter_d;
      eff_q   <= eff_d;
      wd_q    <= wd_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_x_d   = k_x_q;
    u_out_d = u_out_q;
    iter_d  = iter_q;
    eff_d   = eff_q;
    wd_d    = wd_q;
    done_d  = done_q;
    busy_d  = busy_q;
    ovr_d   = ovr_q;
    to_d    = to_q;
    ovr_set = 1'b0;
    to_set  = 1'b0;
    if (bus.ce) begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_d = S_REQ;
            k_x_d   = bus.x_meas;
            eff_d   = (bus.iter_limit == '0 || bus.iter_limit > MAX_L) ? MAX_L : bus.iter_limit;
            iter_d  = '0;
            wd_d    = '0;
          end
        end
        S_REQ: begin
          // The final ack publishes u_out on the same edge that enters FINISH,
          // so done and the new actuation become visible together.
          if (bus.k_ack) begin
            k_x_d  = bus.k_y;
            iter_d = iter_inc;
            wd_d   = '0;
            if (iter_inc == eff_q) begin
              state_d = S_FINISH;
              u_out_d = bus.k_y;
            end
          end else if (wd_q == WD_LAST) begin
            to_set  = 1'b1;
            state_d = S_FINISH;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end
        S_FINISH: state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase

      ovr_set = bus.start && (state_q != S_IDLE);
      if (bus.clear_flags) begin
        ovr_d = 1'b0;
        to_d  = 1'b0;
      end
      if (ovr_set) ovr_d = 1'b1;
      if (to_set)  to_d  = 1'b1;

      done_d = (state_d == S_FINISH);
      busy_d = (state_d != S_IDLE);
    end
  end

  assign bus.k_req        = (state_q == S_REQ) && bus.ce;
  assign bus.k_x          = k_x_q;
  assign bus.done         = done_q;
  assign bus.u_out        = u_out_q;
  assign bus.busy         = busy_q;
  assign bus.iter_count   = iter_q;
  assign bus.overrun      = ovr_q;
  assign bus.timeout_flag = to_q;
endmodule
